// File: rtl/resp_time_framer.sv
// resp_time_framer
//   Measures device response latency in CLK cycles, from the start strobe to
//   the stop strobe. The result goes to the host UART as a framed packet,
//   sent least significant byte first:
//     SYNC_BYTE, status, cnt[7:0] .. cnt[CNT_W-1:CNT_W-8] [, CHK]
//   The status byte carries two flags: bit0 = timed out, bit1 = a second
//   start arrived during COUNT.
//
//   Optional feature: define RESP_CHKSUM_EN to append a CHK byte. CHK is the
//   XOR of the status byte and all count bytes (SYNC is excluded). When the
//   macro is undefined, the frame ends after the last count byte.
//
// Ports
//   CLK      in   system clock, posedge
//   rst      in   synchronous active-low reset
//   start    in   strobe: last attempt byte handed to the device transmitter
//   stop     in   strobe: first response byte valid from the device receiver
//   abort    in   strobe: drop the measurement or frame and return to IDLE
//   tx_rdy   in   uart_tx may accept a byte
//   tx_en    out  1-cycle byte strobe to uart_tx
//   tx_data  out  byte for uart_tx; holds its value between strobes
//   busy     out  any state other than IDLE
//   timeout  out  sticky: the last measurement timed out
module resp_time_framer #(
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] TIMEOUT   = 32'd1_300_000_000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       abort,
  input  logic       tx_rdy,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned CNT_BYTES = CNT_W / 8;
`ifdef RESP_CHKSUM_EN
  localparam int unsigned FRAME_LEN = 3 + CNT_BYTES;
`else
  localparam int unsigned FRAME_LEN = 2 + CNT_BYTES;
`endif
  localparam int unsigned IDX_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, COUNT, SEND, GAP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       status;
  logic             overlap;
  logic [IDX_W-1:0] byte_idx;
  logic [7:0]       frame_byte;
  logic             strobe;
  logic             cnt_hit;

  assign cnt_hit = (cnt == TIMEOUT_CNT);

  // Abort overrides every other transition, including a start seen in IDLE.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_next = COUNT;
        COUNT:   if (stop || cnt_hit) state_next = SEND;
        SEND:    if (tx_rdy) state_next = GAP;
        GAP:     state_next = (byte_idx == LAST_IDX) ? IDLE : SEND;
        default: state_next = IDLE;
      endcase
    end
  end

  // Byte selection for the current frame position. During SEND and GAP the
  // count register is frozen, so it holds the reported value.
  always_comb begin
`ifdef RESP_CHKSUM_EN
    logic [7:0] chk;
    chk = status;
    for (int unsigned i = 0; i < CNT_BYTES; i++) chk = chk ^ cnt[8*i +: 8];
`endif
    frame_byte = SYNC_BYTE;
    if (byte_idx == IDX_W'(1)) frame_byte = status;
    for (int unsigned i = 0; i < CNT_BYTES; i++) begin
      if (byte_idx == IDX_W'(i + 2)) frame_byte = cnt[8*i +: 8];
    end
`ifdef RESP_CHKSUM_EN
    if (byte_idx == IDX_W'(FRAME_LEN - 1)) frame_byte = chk;
`endif
    strobe = (state == SEND) && tx_rdy && !abort;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (!rst) begin
      state    <= IDLE;
      tx_en    <= 1'b0;
      tx_data  <= 8'h00;
      timeout  <= 1'b0;
      cnt      <= '0;
      status   <= '0;
      overlap  <= 1'b0;
      byte_idx <= '0;
    end else begin
      state <= state_next;
      tx_en <= strobe;
      if (strobe) begin
        tx_data  <= frame_byte;
        byte_idx <= byte_idx + IDX_W'(1);
      end
      if (!abort) begin
        unique case (state)
          IDLE: if (start) begin
            cnt     <= CNT_W'(1);
            overlap <= 1'b0;
            timeout <= 1'b0;
          end
          COUNT: begin
            if (stop) begin
              status <= {6'b0, overlap, 1'b0};
            end else if (cnt_hit) begin
              status  <= {6'b0, overlap, 1'b1};
              timeout <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
            if (start) overlap <= 1'b1;
          end
          GAP:     if (byte_idx == LAST_IDX) byte_idx <= '0;
          default: ;
        endcase
      end else begin
        byte_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_resp_time_framer.sv
module tb_resp_time_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, stop = 1'b0, abort = 1'b0, tx_rdy = 1'b1;
  logic       tx_en, busy, timeout;
  logic [7:0] tx_data;

  int         checks = 0;
  int         errors = 0;
  int         en_count = 0;
  int         base;
  logic [7:0] sb[$];
  logic [7:0] last_byte = 8'h00;
  logic [7:0] exp_b;
  logic       saw_en, changed;

  resp_time_framer #(
    .CNT_W(32),
    .TIMEOUT(32'd400),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .CLK(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .abort(abort),
    .tx_rdy(tx_rdy),
    .tx_en(tx_en),
    .tx_data(tx_data),
    .busy(busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Scoreboard side: every strobed byte must match the next queued byte.
  always @(negedge clk) begin
    if (tx_en === 1'b1) begin
      en_count++;
      exp_b = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
      checks++;
      assert (tx_data === exp_b) else begin
        errors++;
        $error("FAIL tx_byte got %h exp %h", tx_data, exp_b);
      end
      last_byte = exp_b;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no_finish exp finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] st, input logic [31:0] c, input int n);
    logic [7:0] f[7];
    int len;
    f[0] = 8'hA5;
    f[1] = st;
    f[2] = c[7:0];
    f[3] = c[15:8];
    f[4] = c[23:16];
    f[5] = c[31:24];
    f[6] = st ^ c[7:0] ^ c[15:8] ^ c[23:16] ^ c[31:24];
`ifdef RESP_CHKSUM_EN
    len = 7;
`else
    len = 6;
`endif
    for (int i = 0; i < len && i < n; i++) sb.push_back(f[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop(input logic [7:0] st, input logic [31:0] c, input int n);
    stop = 1'b1;
    push_frame(st, c, n);
    cyc(1);
    stop = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int k = 0;
    while (busy !== 1'b0 && k < lim) begin
      cyc(1);
      k++;
    end
    chk(tag, {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_en(input string tag, input int target, input int lim);
    int k = 0;
    while (en_count < target && k < lim) begin
      cyc(1);
      k++;
    end
    chk(tag, en_count, target);
  endtask

  initial begin
    // Reset values
    cyc(3);
    chk("rst_tx_en", {31'b0, tx_en}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_timeout", {31'b0, timeout}, 32'd0);
    rst = 1'b1;
    cyc(2);

    // Normal measurement: 100 cycles
    pulse_start();
    chk("t1_busy", {31'b0, busy}, 32'd1);
    cyc(99);
    pulse_stop(8'h00, 32'd100, 7);
    wait_idle("t1_idle", 100);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_timeout", {31'b0, timeout}, 32'd0);

    // Timeout: no stop, count saturates at TIMEOUT
    pulse_start();
    push_frame(8'h01, 32'd400, 7);
    wait_idle("t2_idle", 600);
    chk("t2_sb_empty", sb.size(), 0);
    cyc(5);
    chk("t2_timeout_sticky", {31'b0, timeout}, 32'd1);

    // Second start during COUNT: overlap flag set, count from first start
    pulse_start();
    chk("t3_timeout_clr", {31'b0, timeout}, 32'd0);
    cyc(4);
    pulse_start();
    cyc(294);
    pulse_stop(8'h02, 32'd300, 7);
    wait_idle("t3_idle", 100);
    chk("t3_sb_empty", sb.size(), 0);

    // tx_rdy held low: no strobes, tx_data holds, then the frame completes
    pulse_start();
    cyc(19);
    tx_rdy = 1'b0;
    pulse_stop(8'h00, 32'd20, 7);
    saw_en = 1'b0;
    changed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (tx_en !== 1'b0) saw_en = 1'b1;
      if (tx_data !== last_byte) changed = 1'b1;
    end
    chk("t4_no_en", {31'b0, saw_en}, 32'd0);
    chk("t4_data_hold", {31'b0, changed}, 32'd0);
    chk("t4_busy", {31'b0, busy}, 32'd1);
    tx_rdy = 1'b1;
    wait_idle("t4_idle", 100);
    chk("t4_sb_empty", sb.size(), 0);

    // Abort mid-COUNT, then a fresh measurement starts from 1
    base = en_count;
    pulse_start();
    cyc(10);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("t5_busy", {31'b0, busy}, 32'd0);
    cyc(20);
    chk("t5_no_en", en_count, base);
    pulse_start();
    cyc(9);
    pulse_stop(8'h00, 32'd10, 7);
    wait_idle("t5_idle", 100);
    chk("t5_sb_empty", sb.size(), 0);

    // Abort after the third byte of SEND
    base = en_count;
    pulse_start();
    cyc(4);
    pulse_stop(8'h00, 32'd5, 3);
    wait_en("t6_wait", base + 3, 50);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("t6_busy", {31'b0, busy}, 32'd0);
    cyc(20);
    chk("t6_en_count", en_count, base + 3);
    chk("t6_sb_empty", sb.size(), 0);

    // Reset mid-SEND
    base = en_count;
    pulse_start();
    cyc(6);
    pulse_stop(8'h00, 32'd7, 3);
    wait_en("t7_wait", base + 3, 50);
    rst = 1'b0;
    cyc(1);
    chk("t7_tx_en", {31'b0, tx_en}, 32'd0);
    chk("t7_tx_data", {24'b0, tx_data}, 32'd0);
    chk("t7_busy", {31'b0, busy}, 32'd0);
    chk("t7_timeout", {31'b0, timeout}, 32'd0);
    rst = 1'b1;
    cyc(10);
    chk("t7_en_count", en_count, base + 3);
    chk("t7_sb_empty", sb.size(), 0);

    // start+stop together in IDLE: start wins, stop ignored
    start = 1'b1;
    stop = 1'b1;
    cyc(1);
    start = 1'b0;
    stop = 1'b0;
    chk("t8_busy", {31'b0, busy}, 32'd1);
    cyc(29);
    pulse_stop(8'h00, 32'd30, 7);
    wait_idle("t8_idle", 100);
    chk("t8_sb_empty", sb.size(), 0);

    // abort+start together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    cyc(1);
    start = 1'b0;
    abort = 1'b0;
    chk("t9_busy", {31'b0, busy}, 32'd0);
    cyc(5);
    chk("t9_busy_later", {31'b0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
